// File: rtl/uart_tx_word.sv
// Word-oriented 8N1 UART transmitter with a one-word holding buffer.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_word #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [15:0] tx_data,
  input  logic        tx_len,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        txd
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

  // Holding register
  logic        hold_full_q, hold_full_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic        hold_len_q,  hold_len_d;

  // Shifter / FSM
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       hi_q;
  logic             pend_q;
  logic             txd_q;
  logic             done_q;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  logic load, accept, wrap;

  assign load   = (state_q == IDLE) && hold_full_q;
  assign accept = tx_valid && !hold_full_q;
  assign wrap   = (cnt_q == CNT_MAX);

  // Load and accept are mutually exclusive: load needs a full hold, accept an empty one.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    if (load) hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
      hold_len_d  = tx_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_len_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hi_q    <= '0;
      pend_q  <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          cnt_q <= '0;
          if (hold_full_q) begin
            shift_q <= hold_data_q[7:0];
            hi_q    <= hold_data_q[15:8];
            pend_q  <= hold_len_q;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^hold_data_q[7:0];
`endif
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (wrap) begin
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= par_q;
              state_q <= PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shift_q[1];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (wrap) begin
            txd_q   <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          // Registered pulse: raise it one cycle early so it covers the final stop cycle.
          if (!pend_q && cnt_q == CNT_PRE) done_q <= 1'b1;
          if (wrap) begin
            if (pend_q) begin
              pend_q  <= 1'b0;
              shift_q <= hi_q;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^hi_q;
`endif
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx_busy  = hold_full_q || (state_q != IDLE);
  assign tx_done  = done_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Randomized bench for uart_tx_word; expected line levels come from a frame-position model.
module tb_uart_tx_word;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_len;
  logic        tx_ready, tx_busy, tx_done, txd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_word #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_len(tx_len),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level in cycle t (1-based) of a word's transmission.
  function automatic logic exp_txd(input logic [15:0] w, input int t);
    int idx, pos;
    logic [7:0] b;
    idx = (t - 1) / CPB;
    pos = idx % FB;
    b   = ((idx / FB) != 0) ? w[15:8] : w[7:0];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == FB - 1) return 1'b1;
    return ^b;
  endfunction

  function automatic int word_cycles(input logic len);
    return (len ? 2 : 1) * FB * CPB;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_len = 1'b0;
    step(); step();
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: txd=%b ready=%b busy=%b done=%b, want 1 1 0 0",
               txd, tx_ready, tx_busy, tx_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc%0d: txd=%b ready=%b busy=%b done=%b, want 1 1 0 0",
                 i, txd, tx_ready, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_word(input logic [15:0] w, input logic len);
    int n;
    for (int i = 0; i < 2000 && tx_ready !== 1'b1; i++) step();
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL word_ready_timeout: ready=%b, want 1", tx_ready);
    end
    tx_data = w; tx_len = len; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0; tx_data = 16'($urandom);
    checks++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || txd !== 1'b1) begin
      errors++;
      $display("FAIL word_accept %h: ready=%b busy=%b txd=%b, want 0 1 1", w, tx_ready, tx_busy, txd);
    end
    step();
    n = word_cycles(len);
    for (int t = 1; t <= n; t++) begin
      checks++;
      if (txd !== exp_txd(w, t) || tx_done !== (t == n) || tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL word %h len%0d cyc%0d: txd=%b done=%b busy=%b, want %b %b 1",
                 w, len, t, txd, tx_done, tx_busy, exp_txd(w, t), (t == n));
      end
      step();
    end
    checks++;
    if (txd !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL word_end %h: txd=%b done=%b busy=%b ready=%b, want 1 0 0 1",
               w, txd, tx_done, tx_busy, tx_ready);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) test_word(16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, c;
    logic la, lb;
    int na, nb;
    logic et, ed, eb;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    la = 1'($urandom_range(0, 1)); lb = 1'($urandom_range(0, 1));
    na = word_cycles(la); nb = word_cycles(lb);
    for (int i = 0; i < 2000 && tx_ready !== 1'b1; i++) step();
    tx_data = a; tx_len = la; tx_valid = 1'b1;
    step();
    tx_data = b; tx_len = lb;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_a_held: ready=%b, want 0", tx_ready);
    end
    for (int t = 1; t <= na + nb + 20; t++) begin
      step();
      if (t == 1) begin
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold_empty: ready=%b, want 1", tx_ready);
        end
      end
      if (t == 2) begin
        checks++;
        if (tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_b_held: ready=%b, want 0", tx_ready);
        end
        tx_data = c; tx_len = ~lb;
      end
      if (t == 8) tx_valid = 1'b0;
      if (t == na + 2) begin
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_b_loaded: ready=%b, want 1", tx_ready);
        end
      end
      if (t <= na)               et = exp_txd(a, t);
      else if (t == na + 1)      et = 1'b1;
      else if (t <= na + 1 + nb) et = exp_txd(b, t - na - 1);
      else                       et = 1'b1;
      ed = (t == na) || (t == na + 1 + nb);
      eb = (t <= na + 1 + nb);
      checks++;
      if (txd !== et || tx_done !== ed || tx_busy !== eb) begin
        errors++;
        $display("FAIL b2b cyc%0d: txd=%b done=%b busy=%b, want %b %b %b",
                 t, txd, tx_done, tx_busy, et, ed, eb);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 2000 && tx_ready !== 1'b1; i++) step();
    tx_data = 16'h00FF; tx_len = 1'b0; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    for (int i = 0; i < 12; i++) step();
    tx_data = 16'($urandom); tx_len = 1'b1; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    checks++;
    if (tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_held: busy=%b ready=%b, want 1 0", tx_busy, tx_ready);
    end
    rst = 1'b1;
    step();
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_edge: txd=%b busy=%b ready=%b done=%b, want 1 0 1 0",
               txd, tx_busy, tx_ready, tx_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after cyc%0d: txd=%b busy=%b done=%b, want 1 0 0",
                 i, txd, tx_busy, tx_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word(16'h00A5, 1'b0);
    test_word(16'h3C5A, 1'b1);
    test_word(16'h0007, 1'b0);
    test_random();
    test_back_to_back();
    test_back_to_back();
    test_reset_mid_frame();
    test_word(16'($urandom), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_word.md
Name: uart_tx_word

Overview:
- Serial transmit end of the CPU's UART path. The CPU's receive side deposits incoming bytes into RAM via BYTE_READY; this block takes words from the datapath when a UART-class instruction executes and shifts them out on txd as 8N1 frames.
- Provides one-word holding buffer plus a ready/busy handshake so the control path can stall the UART instruction while the shifter is occupied.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- CNT_W, 16, width of baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- tx_valid  in  1  word offered by datapath this cycle
- tx_data  in  16  word to send; byte 0 = [7:0], byte 1 = [15:8]
- tx_len  in  1  0: send tx_data[7:0] only; 1: send [7:0] then [15:8]
- tx_ready  out  1  holding register empty; accept occurs when tx_valid && tx_ready at clock edge
- tx_busy  out  1  holding register full or shifter not IDLE
- tx_done  out  1  one-cycle pulse at end of last stop bit of a word
- txd  out  1  serial line, idle high, registered

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: txd=1, tx_ready=1, tx_busy=0, tx_done=0. Holding register is cleared (hold_full=0). FSM goes to IDLE. Baud counter and bit index are 0.
- Reset mid-frame aborts the frame: txd=1 after the reset edge, and any held word is discarded.
- tx_ready = !hold_full (combinational from register).
- tx_busy = hold_full || state!=IDLE.
- Accept edge E0: tx_data and tx_len are captured into the hold register; hold_full=1.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - txd=1.
  - If hold_full: load the shifter with byte 0, latch the byte count (tx_len), clear hold_full, go to START.
  - For an idle block, the load happens at edge E1 = E0+1, so txd=0 is first visible after E1.
  - A new word may be accepted at the same edge that hold empties only if tx_ready was 1 when sampled; the word accepted is then the next queued word.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - txd = shifter LSB; each bit lasts CLKS_PER_BIT cycles; shift right after each bit.
  - After bit 7, go to STOP.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - At the end of the stop bit, if byte 1 is pending (tx_len=1 and byte 0 just finished): load [15:8] and go directly to START, with no idle gap.
  - Otherwise: assert tx_done during the final stop cycle and go to IDLE.
- Back-to-back words: if hold_full at IDLE entry, the next start bit begins one cycle after the STOP→IDLE transition. There is exactly one idle-high cycle between words, none between bytes of a word.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit transitions occur only at wrap; there is no fractional baud.
- Frame length per byte = 10*CLKS_PER_BIT cycles.
- tx_valid while tx_ready=0 is ignored; the data is not captured and the datapath must hold the value.

Optional Feature:
- UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits an even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles per byte.
- Undefined: 8N1 as above; no PARITY state is synthesized.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: txd=1, tx_ready=1, tx_busy=0 for 20 cycles with no tx_valid.
- Accept 0x00A5, tx_len=0:
  - txd after E1 = 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles).
  - tx_done high exactly on cycle 40 after E1; tx_busy low the cycle after.
- Accept 0x3C5A, tx_len=1:
  - Bytes 0x5A then 0x3C sent back-to-back; 80 cycles total with no idle gap.
  - tx_done pulses once only, at the end of the 0x3C stop bit.
- Queueing:
  - Accept word A, then offer word B at E0+1: B is accepted (hold emptied at E1).
  - Offer C while B is held: tx_ready=0, C not captured.
  - B starts one cycle after A's tx_done.
- Reset asserted mid-DATA of 0x00FF with a word held: txd=1 after the reset edge, tx_busy=0, tx_ready=1; no further frame appears.
- With UART_TX_PARITY_EN, send 0x0007: data bits 1,1,1,0,0,0,0,0, parity bit=1, then stop; 44 cycles at CLKS_PER_BIT=4.
